// File: rtl/decode_issue_stage_pkg.sv
// decode_issue_stage_pkg: ALU opcodes, RV32 major opcodes and decode types shared with the ALU
package decode_issue_stage_pkg;
  localparam logic [7:0] ALU_ADD   = 8'd0;
  localparam logic [7:0] ALU_SUB   = 8'd1;
  localparam logic [7:0] ALU_AND   = 8'd2;
  localparam logic [7:0] ALU_OR    = 8'd3;
  localparam logic [7:0] ALU_XOR   = 8'd4;
  localparam logic [7:0] ALU_SLT   = 8'd5;
  localparam logic [7:0] ALU_SLTU  = 8'd6;
  localparam logic [7:0] ALU_SRA   = 8'd7;
  localparam logic [7:0] ALU_SRL   = 8'd8;
  localparam logic [7:0] ALU_SLL   = 8'd9;
  localparam logic [7:0] ALU_MUL   = 8'd10;
  localparam logic [7:0] ALU_LUI   = 8'd11;
  localparam logic [7:0] ALU_AUIPC = 8'd12;
  localparam logic [7:0] ALU_LW    = 8'd13;
  localparam logic [7:0] ALU_SW    = 8'd14;
  localparam logic [7:0] ALU_BEQ   = 8'd18;
  localparam logic [7:0] ALU_BNE   = 8'd19;
  localparam logic [7:0] ALU_BLT   = 8'd20;
  localparam logic [7:0] ALU_BGE   = 8'd21;
  localparam logic [7:0] ALU_BLTU  = 8'd22;
  localparam logic [7:0] ALU_BGEU  = 8'd23;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  typedef struct packed {
    logic [7:0]  alu;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] store_data;
    logic [31:0] target;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
  } bundle_t;

  // alt selects SUB/SRA over ADD/SRL
  function automatic logic [7:0] alu_op_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [7:0] alu_branch(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_BEQ;
      3'b001:  return ALU_BNE;
      3'b100:  return ALU_BLT;
      3'b101:  return ALU_BGE;
      3'b110:  return ALU_BLTU;
      default: return ALU_BGEU;
    endcase
  endfunction
endpackage

// File: rtl/decode_issue_stage_if.sv
// decode_issue_stage_if: fetch-side input, execute-side bundle and decode statistics
interface decode_issue_stage_if #(
  parameter int CNT_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instr;
  logic [31:0]       pc;
  logic [31:0]       rs1_data;
  logic [31:0]       rs2_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        alu_control;
  logic [31:0]       op_a;
  logic [31:0]       op_b;
  logic [31:0]       store_data;
  logic [31:0]       target;
  logic [31:0]       out_pc;
  logic [4:0]        rd;
  logic              reg_write;
  logic              mem_read;
  logic              mem_write;
  logic              branch;
  logic              jump;
  logic              illegal;
  logic [CNT_W-1:0]  decoded_cnt;
  logic [CNT_W-1:0]  illegal_cnt;
  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
    input  in_ready, out_valid, alu_control, op_a, op_b, store_data, target, out_pc, rd,
           reg_write, mem_read, mem_write, branch, jump, illegal, decoded_cnt, illegal_cnt
  );
  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
    output in_ready, out_valid, alu_control, op_a, op_b, store_data, target, out_pc, rd,
           reg_write, mem_read, mem_write, branch, jump, illegal, decoded_cnt, illegal_cnt
  );
endinterface

// File: rtl/rv32_imm_gen.sv
// rv32_imm_gen: extracts the I/S/B/U/J immediate selected by fmt_i
module rv32_imm_gen
  import decode_issue_stage_pkg::*;
(
  input  logic [31:7] instr_i,
  input  imm_fmt_e    fmt_i,
  output logic [31:0] imm_o
);
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
  assign i_imm = {{20{instr_i[31]}}, instr_i[31:20]};
  assign s_imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign b_imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  // U-format feeds the ALU unshifted; the ALU places it in the upper bits
  assign u_imm = {12'h0, instr_i[31:12]};
  assign j_imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  always_comb
    imm_o = fmt_i == IMM_S ? s_imm :
            fmt_i == IMM_B ? b_imm :
            fmt_i == IMM_U ? u_imm :
            fmt_i == IMM_J ? j_imm : i_imm;
endmodule

// File: rtl/decode_issue_stage.sv
// decode_issue_stage: RV32I+MUL decode into a one-entry registered ALU issue bundle
// with valid/ready handshake, flush and decode counters.
module decode_issue_stage
  import decode_issue_stage_pkg::*;
#(
  parameter int          CNT_W        = 16,
  parameter logic [31:0] RESET_PC_TAG = 32'h0
) (
  input logic                 clk,
  input logic                 rst,
  decode_issue_stage_if.slave bus_io
);
  logic [6:0]       opc, f7;
  logic [2:0]       f3;
  logic [4:0]       rd_f;
  logic [31:0]      rs1, rs2, pc, imm;
  imm_fmt_e         fmt;
  bundle_t          dec, bun_q, bun_d;
  logic             val_q, val_d, accept;
  logic [CNT_W-1:0] dcnt_q, dcnt_d, icnt_q, icnt_d;

  assign opc  = bus_io.instr[6:0];
  assign rd_f = bus_io.instr[11:7];
  assign f3   = bus_io.instr[14:12];
  assign f7   = bus_io.instr[31:25];
  assign rs1  = bus_io.rs1_data;
  assign rs2  = bus_io.rs2_data;
  assign pc   = bus_io.pc;

  assign fmt = opc == OPC_STORE                    ? IMM_S :
               opc == OPC_BRANCH                   ? IMM_B :
               opc == OPC_LUI || opc == OPC_AUIPC  ? IMM_U :
               opc == OPC_JAL                      ? IMM_J : IMM_I;

  rv32_imm_gen u_imm_gen (
    .instr_i (bus_io.instr[31:7]),
    .fmt_i   (fmt),
    .imm_o   (imm)
  );

  // Everything starts illegal/zero; each legal encoding overwrites what it needs
  always_comb begin
    dec         = '0;
    dec.pc      = pc;
    dec.illegal = 1'b1;
    case (opc)
      OPC_OP:
        if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) ||
            (f7 == 7'b0000001 && f3 == 3'b000)) begin
          dec.illegal = 1'b0;
          dec.alu     = f7[0] ? ALU_MUL : alu_op_f3(f3, f7[5]);
          dec.op_a    = rs1;
          dec.op_b    = rs2;
          dec.rd      = rd_f;
        end
      OPC_OP_IMM:
        if (f3[1:0] != 2'b01 || f7 == 7'b0000000 || (f3 == 3'b101 && f7 == 7'b0100000)) begin
          dec.illegal = 1'b0;
          dec.alu     = alu_op_f3(f3, f3 == 3'b101 && f7[5]);
          dec.op_a    = rs1;
          dec.op_b    = f3[1:0] == 2'b01 ? {27'd0, bus_io.instr[24:20]} : imm;
          dec.rd      = rd_f;
        end
      OPC_LUI: begin
        dec.illegal = 1'b0;
        dec.alu     = ALU_LUI;
        dec.op_b    = imm;
        dec.rd      = rd_f;
      end
      OPC_AUIPC: begin
        dec.illegal = 1'b0;
        dec.alu     = ALU_AUIPC;
        dec.op_a    = pc;
        dec.op_b    = imm;
        dec.rd      = rd_f;
      end
      OPC_LOAD:
        if (f3 == 3'b010) begin
          dec.illegal  = 1'b0;
          dec.alu      = ALU_LW;
          dec.op_a     = rs1;
          dec.op_b     = imm;
          dec.mem_read = 1'b1;
          dec.rd       = rd_f;
        end
      OPC_STORE:
        if (f3 == 3'b010) begin
          dec.illegal    = 1'b0;
          dec.alu        = ALU_SW;
          dec.op_a       = rs1;
          dec.op_b       = imm;
          dec.store_data = rs2;
          dec.mem_write  = 1'b1;
        end
      OPC_BRANCH:
        if (f3[2:1] != 2'b01) begin
          dec.illegal = 1'b0;
          dec.alu     = alu_branch(f3);
          dec.op_a    = rs1;
          dec.op_b    = rs2;
          dec.target  = pc + imm;
          dec.branch  = 1'b1;
        end
      OPC_JAL: begin
        dec.illegal = 1'b0;
        dec.alu     = ALU_ADD;
        dec.op_a    = pc;
        dec.op_b    = 32'd4;
        dec.target  = pc + imm;
        dec.jump    = 1'b1;
        dec.rd      = rd_f;
      end
      OPC_JALR:
        if (f3 == 3'b000) begin
          dec.illegal = 1'b0;
          dec.alu     = ALU_ADD;
          dec.op_a    = pc;
          dec.op_b    = 32'd4;
          dec.target  = (rs1 + imm) & ~32'd1;
          dec.jump    = 1'b1;
          dec.rd      = rd_f;
        end
      default: ;
    endcase
    dec.reg_write = dec.rd != 5'd0;
  end

  assign bus_io.in_ready = !val_q || bus_io.out_ready;
  assign accept = bus_io.in_valid && bus_io.in_ready && !bus_io.flush;
  assign val_d  = accept || (val_q && !bus_io.out_ready && !bus_io.flush);
  assign bun_d  = accept ? dec : bun_q;
  assign dcnt_d = accept ? dcnt_q + CNT_W'(1) : dcnt_q;
  assign icnt_d = accept && dec.illegal && icnt_q != '1 ? icnt_q + CNT_W'(1) : icnt_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      val_q  <= 1'b0;
      bun_q  <= '0;
      dcnt_q <= '0;
      icnt_q <= '0;
    end else begin
      val_q  <= val_d;
      bun_q  <= bun_d;
      dcnt_q <= dcnt_d;
      icnt_q <= icnt_d;
    end

  assign bus_io.out_valid   = val_q;
  assign bus_io.alu_control = bun_q.alu;
  assign bus_io.op_a        = bun_q.op_a;
  assign bus_io.op_b        = bun_q.op_b;
  assign bus_io.store_data  = bun_q.store_data;
  assign bus_io.target      = bun_q.target;
  assign bus_io.out_pc      = val_q ? bun_q.pc : RESET_PC_TAG;
  assign bus_io.rd          = bun_q.rd;
  assign bus_io.reg_write   = bun_q.reg_write;
  assign bus_io.mem_read    = bun_q.mem_read;
  assign bus_io.mem_write   = bun_q.mem_write;
  assign bus_io.branch      = bun_q.branch;
  assign bus_io.jump        = bun_q.jump;
  assign bus_io.illegal     = bun_q.illegal;
  assign bus_io.decoded_cnt = dcnt_q;
  assign bus_io.illegal_cnt = icnt_q;
endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Registered instruction decode/issue stage that drives the ALU interface: alu_control (8-bit), op_a and op_b (32-bit).
- Sits between fetch/register-file read and execute in each lockstep core.
- Converts RV32I+MUL instruction words into ALU opcodes, selected operands, immediates and control flags.
- One-entry output register with valid/ready handshake, flush and decode statistics.

Parameters:
- CNT_W, 16, width of the decoded-instruction and illegal-instruction counters.
- RESET_PC_TAG, 32'h0, value driven on out_pc while out_valid=0 (debug visibility).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch offers instr/pc/register data.
- in_ready  out  1  stage can accept this cycle.
- instr  in  32  instruction word.
- pc  in  32  instruction address.
- rs1_data  in  32  register-file read for instr[19:15], valid with in_valid.
- rs2_data  in  32  register-file read for instr[24:20], valid with in_valid.
- flush  in  1  discard held and incoming instruction.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts bundle.
- alu_control  out  8  ALU opcode.
- op_a  out  32  ALU operand 1.
- op_b  out  32  ALU operand 2.
- store_data  out  32  rs2_data for SW, else 0.
- target  out  32  branch/jump target.
- out_pc  out  32  pc of held instruction.
- rd  out  5  destination register, 0 when no write.
- reg_write, mem_read, mem_write, branch, jump, illegal  out  1 each  control flags.
- decoded_cnt  out  CNT_W  accepted instructions, wraps.
- illegal_cnt  out  CNT_W  accepted illegal instructions, saturates.

Behaviour:
- Reset (async assert, sync release): out_valid=0; all bundle outputs 0 except out_pc=RESET_PC_TAG; both counters 0.
- Handshake: in_ready = !out_valid | out_ready (combinational).
- Accept = in_valid & in_ready & !flush. Accepted bundle appears the next cycle: latency 1, throughput 1.
- Bundle holds stable while out_valid & !out_ready.
- out_valid next = accept | (out_valid & !out_ready & !flush).
- flush: out_valid=0 next cycle; no input accepted that cycle; counters unchanged.
- ALU opcode codes: ADD0 SUB1 AND2 OR3 XOR4 SLT5 SLTU6 SRA7 SRL8 SLL9 MUL10 LUI11 AUIPC12 LW13 SW14 BEQ18 BNE19 BLT20 BGE21 BLTU22 BGEU23. Codes 15-17 are never emitted.
- R-type (0110011): op_a=rs1, op_b=rs2.
  - funct7 0000000: standard op.
  - funct7 0100000: SUB or SRA only.
  - funct7 0000001 with funct3 000: MUL.
  - Other encodings are illegal.
- I-ALU (0010011): op_b = sign-extended imm[11:0].
  - Shifts use op_b = zero-extended shamt.
  - SRAI requires funct7 0100000; SLLI/SRLI require funct7 0000000.
- LUI: op_b = {12'h0, instr[31:12]}, op_a=0.
- AUIPC: op_a=pc, op_b = {12'h0, instr[31:12]}.
- LW (funct3 010 only): code 13, op_a=rs1, op_b=I-imm, mem_read=1.
- SW (funct3 010 only): code 14, op_b=S-imm, mem_write=1, rd=0, reg_write=0.
- Branches: codes 18-23 by funct3 (000,001,100,101,110,111); op_a=rs1, op_b=rs2; target=pc+B-imm; branch=1; rd=0.
- JAL: code ADD, op_a=pc, op_b=4, target=pc+J-imm, jump=1.
- JALR (funct3 000): code ADD, op_a=pc, op_b=4, target=(rs1+I-imm)&~1, jump=1.
- rd=0 forces reg_write=0.
- Illegal (unknown opcode/funct, other load/store widths, FENCE/SYSTEM):
  - illegal=1, code 0, op_a=op_b=0, all other flags 0.
  - Still counts as decoded.
- All arithmetic is modulo 2^32; target wraps.
- decoded_cnt increments per accept and wraps. illegal_cnt saturates at all-ones.

Decomposition:
- Shared package: ALU opcode constants (0-23), RV32 opcode constants, immediate-format enum.
- The ALU already uses the same opcode values; both must import the package.
- One sub-module: rv32_imm_gen (combinational I/S/B/U/J immediate extraction).

Test Plan:
- ADDI 0x00500093, pc=0x100, rs1_data=7 -> next cycle alu_control=0, op_a=7, op_b=5, rd=1, reg_write=1, out_pc=0x100.
- SUB 0x402081B3, rs1=10, rs2=3 -> alu_control=1, op_a=10, op_b=3, rd=3. Also LUI 0x123452B7 -> alu_control=11, op_b=0x00012345, rd=5.
- BEQ 0x00208463, pc=0x200 -> alu_control=18, target=0x208, branch=1, reg_write=0, rd=0.
- Stall: out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, bundle unchanged, decoded_cnt unchanged. Release -> next instruction appears one cycle later.
- Illegal 0xFFFFFFFF -> illegal=1, alu_control=0, reg_write=0, illegal_cnt 0->1. flush with out_valid=1 -> out_valid=0 next cycle, counters unchanged.
- Reset asserted mid-stall -> out_valid=0 and counters=0 immediately, without waiting for a clock edge.
